// File: rtl/mem_dump_reader_if.sv
// Output word stream of the data-memory dump reader.
// Valid/ready handshake with a last-word marker.
interface mem_dump_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Streams a window of data memory out on a valid/ready port.
// Define DUMP_CHECKSUM_EN to add the o_checksum running-sum port.
module mem_dump_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
`ifdef DUMP_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] o_checksum,
`endif
  mem_dump_reader_if.master     out_if
);

  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FLUSH, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_acked;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_occ;

  logic [ADDR_WIDTH:0]   w_count;
  logic                  w_accept;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_head;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last_word;
  logic                  w_hs;
  logic                  w_push;
  logic                  w_pop;

  assign w_count  = (i_count > MAX_CNT) ? MAX_CNT : i_count;
  assign w_accept = (r_state == S_IDLE) && i_start;

  // Room counts the read still in flight so the FIFO never overflows.
  assign w_room  = (r_occ == 2'd0) ||
                   ((r_occ == 2'd1) && !r_inflight);
  assign w_issue = (r_state == S_RUN) && w_room &&
                   (r_issued < r_count);

  // Empty FIFO: returning read data is presented directly.
  assign w_head  = (r_occ != 2'd0);
  assign w_valid = w_head || r_inflight;
  assign w_data  = w_head     ? r_fifo[r_rp] :
                   r_inflight ? i_mem_rd_data : '0;

  assign w_last_word = (r_acked == r_count - ONE);
  assign w_hs   = w_valid && out_if.out_ready;
  assign w_push = r_inflight && !(!w_head && w_hs);
  assign w_pop  = w_hs && w_head;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start)
          w_next = (w_count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_issue && (r_issued == r_count - ONE))
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_hs && w_last_word)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_acked    <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr   <= i_base_addr;
        r_count  <= w_count;
        r_issued <= '0;
        r_acked  <= '0;
      end else begin
        if (w_issue) begin
          r_addr     <= r_addr + 1'b1;
          r_mem_addr <= r_addr;
          r_issued   <= r_issued + ONE;
        end
        if (w_hs)
          r_acked <= r_acked + ONE;
      end
      if (w_push) begin
        r_fifo[r_wp] <= i_mem_rd_data;
        r_wp         <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_sum <= '0;
    else if (w_accept)
      r_sum <= '0;
    else if (w_hs)
      r_sum <= r_sum + w_data;
  end

  assign o_checksum = r_sum;
`endif

  assign o_busy      = (r_state == S_RUN) ||
                       (r_state == S_FLUSH) || w_accept;
  assign o_done      = (r_state == S_DONE);
  assign o_mem_rd_en = w_issue;
  assign o_mem_addr  = w_issue ? r_addr : r_mem_addr;

  assign out_if.out_valid = w_valid;
  assign out_if.out_data  = w_data;
  assign out_if.out_last  = w_valid && w_last_word;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader against a 1-cycle memory model.
// Checksum checks are compiled in when DUMP_CHECKSUM_EN is defined.
module tb_mem_dump_reader;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   cnt = '0;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] maddr;
  logic [DW-1:0] rd_data;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  always #5 clk = ~clk;

  mem_dump_reader_if #(.DATA_WIDTH(DW)) out_if ();

  mem_dump_reader #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_base_addr(base),
    .i_count(cnt),
    .o_busy(busy),
    .o_done(done),
    .o_mem_rd_en(rd_en),
    .o_mem_addr(maddr),
    .i_mem_rd_data(rd_data),
`ifdef DUMP_CHECKSUM_EN
    .o_checksum(csum),
`endif
    .out_if(out_if)
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk)
    if (rd_en) rd_data <= mem[maddr];

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] rd_log[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc, first_valid, first_hs, last_hs;
  int n_hs, n_done, done_cyc, busy_cnt, n_iss;
  logic          stall = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  // One clock: sample at negedge, scoreboard pop, return at posedge+1.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (busy === 1'b1) busy_cnt++;
    if (rd_en === 1'b1) begin
      rd_log.push_back(maddr);
      n_iss++;
      n_cmp++;
      if (n_iss - n_hs > 2) begin
        n_err++;
        $display("FAIL outstanding: %0d words, required <= 2",
                 n_iss - n_hs);
      end
    end
    if (stall) begin
      n_cmp++;
      if (out_if.out_valid !== 1'b1 ||
          out_if.out_data !== held_d ||
          out_if.out_last !== held_l) begin
        n_err++;
        $display("FAIL stall_hold: v=%b d=%0d l=%b, required v=1 d=%0d l=%b",
                 out_if.out_valid, $signed(out_if.out_data),
                 out_if.out_last, $signed(held_d), held_l);
      end
    end
    if (out_if.out_valid === 1'b1 && first_valid < 0)
      first_valid = cyc;
    if (out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_word: got d=%0d, required no word",
                 $signed(out_if.out_data));
      end else begin
        e = exp_q.pop_front();
        if (out_if.out_data !== e.d || out_if.out_last !== e.l) begin
          n_err++;
          $display("FAIL word: got d=%0d l=%b, required d=%0d l=%b",
                   $signed(out_if.out_data), out_if.out_last,
                   $signed(e.d), e.l);
        end
      end
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      n_hs++;
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    stall  = (out_if.out_valid === 1'b1) && (out_if.out_ready !== 1'b1);
    held_d = out_if.out_data;
    held_l = out_if.out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input int b, input int c);
    base = AW'(b);
    cnt  = (AW+1)'(c);
    for (int i = 0; i < c; i++)
      exp_q.push_back('{d: mem[(b + i) % DEPTH], l: (i == c - 1)});
    first_valid = -1;
    first_hs    = -1;
    last_hs     = -1;
    n_hs        = 0;
    n_done      = 0;
    done_cyc    = -1;
    busy_cnt    = 0;
    n_iss       = 0;
    rd_log.delete();
    start_cyc = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input logic [7:0] pat,
                           input bit hold, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      out_if.out_ready = pat[k % 8];
      start = hold;
      tick();
      if (n_done > 0) ok = 1'b1;
    end
    start = 1'b0;
    out_if.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_if.out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, done, rd_en, maddr} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b done=%b rd_en=%b addr=%0d, required 0",
               busy, done, rd_en, maddr);
    end
    n_cmp++;
    if ({out_if.out_valid, out_if.out_data, out_if.out_last} !== '0) begin
      n_err++;
      $display("FAIL reset_out: v=%b d=%h l=%b, required 0",
               out_if.out_valid, out_if.out_data, out_if.out_last);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int bad;
    start_dump(0, 4);
    wait_done(100, 8'hFF, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL basic_done: no done pulse, required one");
    end
    n_cmp++;
    if (first_valid - start_cyc != 2) begin
      n_err++;
      $display("FAIL basic_latency: %0d cycles, required 2",
               first_valid - start_cyc);
    end
    n_cmp++;
    if (n_hs != 4 || last_hs - first_hs != 3) begin
      n_err++;
      $display("FAIL basic_rate: %0d words over %0d cycles, required 4 over 3",
               n_hs, last_hs - first_hs);
    end
    n_cmp++;
    if (done_cyc != last_hs + 1) begin
      n_err++;
      $display("FAIL basic_done_time: cycle %0d, required %0d",
               done_cyc, last_hs + 1);
    end
    n_cmp++;
    if (busy_cnt != done_cyc - start_cyc) begin
      n_err++;
      $display("FAIL basic_busy: %0d cycles, required %0d",
               busy_cnt, done_cyc - start_cyc);
    end
    bad = 0;
    if (rd_log.size() != 4) bad = 1;
    else
      for (int i = 0; i < 4; i++)
        if (rd_log[i] !== AW'(i)) bad++;
    n_cmp++;
    if (bad != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_reads: %0d reads %0d bad %0d left, required 4 0 0",
               rd_log.size(), bad, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int bad;
    logic [AW-1:0] ea;
    start_dump(30, 4);
    wait_done(100, 8'hFF, 1'b0, ok);
    bad = 0;
    if (rd_log.size() != 4) bad = 1;
    else
      for (int i = 0; i < 4; i++) begin
        ea = AW'(30 + i);
        if (rd_log[i] !== ea) bad++;
      end
    n_cmp++;
    if (!ok || bad != 0 || n_hs != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap: ok=%b bad_addr=%0d words=%0d left=%0d, required 1 0 4 0",
               ok, bad, n_hs, exp_q.size());
    end
  endtask

  task automatic test_zero();
    bit ok;
    start_dump(3, 0);
    wait_done(20, 8'hFF, 1'b0, ok);
    n_cmp++;
    if (!ok || done_cyc != start_cyc + 1) begin
      n_err++;
      $display("FAIL zero_done: ok=%b at +%0d, required done at +1",
               ok, done_cyc - start_cyc);
    end
    n_cmp++;
    if (rd_log.size() != 0 || first_valid >= 0 || busy_cnt != 1) begin
      n_err++;
      $display("FAIL zero_quiet: reads=%0d valid_at=%0d busy=%0d, required 0 -1 1",
               rd_log.size(), first_valid, busy_cnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    start_dump(5, 8);
    wait_done(200, 8'b1010_1001, 1'b0, ok);
    n_cmp++;
    if (!ok || n_hs != 8 || exp_q.size() != 0 || rd_log.size() != 8) begin
      n_err++;
      $display("FAIL stall: ok=%b words=%0d left=%0d reads=%0d, required 1 8 0 8",
               ok, n_hs, exp_q.size(), rd_log.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_dump(0, 10);
    for (int k = 0; k < 50 && n_hs < 2; k++) tick();
    n_cmp++;
    if (n_hs != 2 || out_if.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_setup: words=%0d v=%b, required 2 1",
               n_hs, out_if.out_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, rd_en, maddr, out_if.out_valid,
         out_if.out_data, out_if.out_last} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b v=%b d=%h rd=%b, required all 0",
               busy, out_if.out_valid, out_if.out_data, rd_en);
    end
    tick();
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (n_done != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_no_done: done=%0d busy=%b, required 0 0",
               n_done, busy);
    end
    start_dump(0, 2);
    wait_done(100, 8'hFF, 1'b0, ok);
    n_cmp++;
    if (!ok || n_hs != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_restart: ok=%b words=%0d left=%0d, required 1 2 0",
               ok, n_hs, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_dump(0, 3);
    base = AW'(20);
    cnt  = (AW+1)'(5);
    wait_done(100, 8'hFF, 1'b1, ok);
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (!ok || n_hs != 3 || busy_cnt != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ignore_start: ok=%b words=%0d busy_after=%0d, required 1 3 0",
               ok, n_hs, busy_cnt);
    end
    start_dump(10, 3);
    wait_done(100, 8'hFF, 1'b0, ok);
    n_cmp++;
    if (!ok || n_hs != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL back_to_back: ok=%b words=%0d left=%0d, required 1 3 0",
               ok, n_hs, exp_q.size());
    end
  endtask

  task automatic test_full_depth();
    bit ok;
    int bad;
    logic [AW-1:0] ea;
    start_dump(7, 32);
    wait_done(400, 8'b1101_1011, 1'b0, ok);
    bad = 0;
    if (rd_log.size() != 32) bad = 1;
    else
      for (int i = 0; i < 32; i++) begin
        ea = AW'(7 + i);
        if (rd_log[i] !== ea) bad++;
      end
    n_cmp++;
    if (!ok || bad != 0 || n_hs != 32 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_depth: ok=%b bad_addr=%0d words=%0d, required 1 0 32",
               ok, bad, n_hs);
    end
  endtask

`ifdef DUMP_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    start_dump(0, 32);
    wait_done(200, 8'hFF, 1'b0, ok);
    n_cmp++;
    if (!ok || csum !== 16'hFFF0) begin
      n_err++;
      $display("FAIL csum_full: %h, required fff0", csum);
    end
    start_dump(0, 2);
    n_cmp++;
    if (csum !== 16'h0000) begin
      n_err++;
      $display("FAIL csum_clear: %h, required 0000", csum);
    end
    wait_done(100, 8'hFF, 1'b0, ok);
    tick();
    tick();
    n_cmp++;
    if (!ok || csum !== 16'hFFE1) begin
      n_err++;
      $display("FAIL csum_second: %h, required ffe1", csum);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i - 16);
    out_if.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_full_depth();
`ifdef DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
Reads a contiguous window of the accelerator data memory through a synchronous read port and streams the words out on a valid/ready interface, with a last marker. It is the read-back counterpart to the memory preload path: after a program runs, the host or bench pulls results out with it. It sits beside the accelerator core and uses a dedicated read port on the data memory.

Parameters:
DATA_WIDTH, 16, width of one data-memory word (signed, passed through unmodified)
DEPTH, 32, number of data-memory words
ADDR_WIDTH, 5, memory address width; DEPTH == 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address; sampled with start
count  input  ADDR_WIDTH+1  number of words to emit, 0..DEPTH; sampled with start
busy  output  1  high from the accepted start until done
done  output  1  one-cycle pulse after the last word handshakes
mem_rd_en  output  1  read strobe to data memory
mem_addr  output  ADDR_WIDTH  read address
mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
out_valid  output  1  stream word valid
out_data  output  DATA_WIDTH  stream word
out_last  output  1  marks the final word of the dump, qualified by out_valid
out_ready  input  1  downstream accept

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, mem_rd_en, out_valid, out_last = 0; mem_addr, out_data = 0; FIFO empty; counters cleared. Reset mid-dump abandons the dump. No done pulse is produced and the in-flight read is discarded.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE + start: latch base_addr and count. If count==0, go to DONE (done pulses next cycle, no words emitted, no reads issued). Otherwise go to RUN with busy=1. start outside IDLE is ignored.
- RUN: issue reads at addresses base, base+1, ... modulo DEPTH; addresses wrap, e.g. 31 to 0. A read is issued in any cycle where FIFO occupancy + reads in flight < 2 and reads issued < count. After the final read is issued, go to FLUSH.
- Read data returns 1 cycle later and is written into a 2-entry output FIFO. The FIFO head drives out_data/out_valid. The handshake is out_valid & out_ready.
- Throughput: with out_ready held high, one word per cycle after a 2-cycle initial latency (start to first out_valid = 2 cycles).
- out_valid, once high, stays high and out_data/out_last stay stable until accepted; no word may be dropped or duplicated under any out_ready pattern.
- out_last=1 only on the word whose handshake is the count-th.
- FLUSH: wait until the last word handshakes, then go to DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE. A start in the DONE cycle is ignored.
- mem_rd_en is high only in cycles that issue a read. mem_addr holds its last value otherwise.
- count > DEPTH cannot occur. count==DEPTH reads every word exactly once starting at base_addr.

Optional Feature:
DUMP_CHECKSUM_EN: when defined, adds output port checksum [DATA_WIDTH-1:0], which accumulates the sum modulo 2**DATA_WIDTH of every handshaken out_data. It clears on an accepted start and is valid (stable) from the done pulse until the next accepted start, with a reset value of 0. When undefined, the port and adder are absent and the rest of the behaviour is identical.

Test Plan:
- Memory preloaded mem[i]=i-16; start base=0 count=4, out_ready=1 -> out_data -16,-15,-14,-13 on 4 consecutive cycles, first word 2 cycles after start, out_last on -13, done pulse 1 cycle after it.
- base=30 count=4 -> reads at addresses 30,31,0,1; out_data 14,15,-16,-15; out_last on -15.
- count=0 -> no mem_rd_en, no out_valid, done pulse 1 cycle after start, busy high for 1 cycle.
- base=5 count=8, out_ready toggling 1,0,0,1,0,1,... -> exactly -11..-4 in order with no gaps or repeats; out_data stable while stalled; FIFO never overflows (at most 2 outstanding).
- rst low for 1 cycle during the 3rd word of a count=10 dump -> all outputs 0 immediately, no done. A fresh start base=0 count=2 then yields -16,-15 correctly.
- With DUMP_CHECKSUM_EN defined, base=0 count=32 -> checksum = sum(-16..15) = -16, i.e. 16'hFFF0; a second start clears it before accumulating.
